sysop_commit: RTL and testbench

- Consumer side of the execute-stage system-op cause/tval encoding.
- Accepts one encoded system op per handshake from execute: ECALL, EBREAK, MRET, CSRRW/S/C, or a propagated exception cause.
- Owns the M-mode trap CSRs and the current privilege level.
- Sequences CSR read-modify-write, trap entry and MRET return, then issues a PC redirect to fetch.

---
 rtl/sysop_commit.sv | 240 ++++++++++++++++++++++++
 tb/tb_sysop_commit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysop_commit.sv
// sysop_commit: commits execute-stage system ops (CSR RMW, trap entry, MRET) and owns M-mode trap CSRs.
// Define SYSOP_MCYCLE_EN to add the free-running mcycle counter at CSR 0xB00.
module sysop_commit #(
    parameter int unsigned XLEN       = 64,
    parameter logic [1:0]  RESET_PRIV = 2'b11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      cause_in,
    input  logic [XLEN-1:0] tval_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] wdata_in,
    input  logic [4:0]      rd_in,
    output logic [1:0]      priv,
    output logic            rd_we,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] rd_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [4:0] SYSOP_CSRW   = 5'd16;
    localparam logic [4:0] SYSOP_CSRS   = 5'd17;
    localparam logic [4:0] SYSOP_CSRC   = 5'd18;
    localparam logic [4:0] SYSOP_RET    = 5'd19;
    localparam logic [4:0] SYSOP_ECALL  = 5'd20;
    localparam logic [4:0] SYSOP_EBREAK = 5'd21;

    typedef enum logic [2:0] {
        S_IDLE, S_CSR_RD, S_CSR_WR, S_TRAP, S_RET, S_REDIR
    } state_t;

    state_t r_state, w_next;

    logic [4:0]      r_cause, r_rd;
    logic [XLEN-1:0] r_tval, r_pc, r_wdata, r_old;
    logic            r_illegal;
    logic [1:0]      r_priv;
    logic            r_mie, r_mpie;
    logic [1:0]      r_mpp;
    logic [XLEN-1:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
`ifdef SYSOP_MCYCLE_EN
    logic [XLEN-1:0] r_mcycle;
`endif

    logic [11:0]     w_addr;
    logic            w_csr_hit, w_csr_illegal, w_csr_wen, w_is_w;
    logic [XLEN-1:0] w_csr_rdata, w_csr_new, w_trap_cause, w_trap_tval;

    assign w_addr   = r_tval[11:0];
    assign w_is_w   = (r_cause == SYSOP_CSRW);
    assign w_csr_wen = w_is_w || (r_wdata != '0);
    assign in_ready = (r_state == S_IDLE);
    assign priv     = r_priv;

    always_comb begin
        w_csr_hit   = 1'b1;
        w_csr_rdata = '0;
        case (w_addr)
            12'h300: begin
                w_csr_rdata[3]     = r_mie;
                w_csr_rdata[7]     = r_mpie;
                w_csr_rdata[12:11] = r_mpp;
            end
            12'h305: w_csr_rdata = r_mtvec;
            12'h340: w_csr_rdata = r_mscratch;
            12'h341: w_csr_rdata = r_mepc;
            12'h342: w_csr_rdata = r_mcause;
            12'h343: w_csr_rdata = r_mtval;
            12'hF14: w_csr_rdata = '0;
`ifdef SYSOP_MCYCLE_EN
            12'hB00: w_csr_rdata = r_mcycle;
`endif
            default: w_csr_hit = 1'b0;
        endcase
    end

    // Read-only space (addr[11:10]==3) is legal only for set/clear with a zero mask.
    assign w_csr_illegal = !w_csr_hit || (w_addr[9:8] > r_priv) ||
                           ((w_addr[11:10] == 2'b11) && w_csr_wen);

    always_comb begin
        case (r_cause)
            SYSOP_CSRW: w_csr_new = r_wdata;
            SYSOP_CSRS: w_csr_new = r_old | r_wdata;
            default:    w_csr_new = r_old & ~r_wdata;
        endcase
    end

    always_comb begin
        w_trap_cause = '0;
        w_trap_tval  = r_tval;
        if (r_illegal) begin
            w_trap_cause[4:0] = 5'd2;
            w_trap_tval = (r_cause == SYSOP_RET) ? '0 : {{(XLEN-12){1'b0}}, w_addr};
        end else begin
            case (r_cause)
                SYSOP_ECALL: begin
                    case (r_priv)
                        2'b00:   w_trap_cause[4:0] = 5'd8;
                        2'b01:   w_trap_cause[4:0] = 5'd9;
                        default: w_trap_cause[4:0] = 5'd11;
                    endcase
                    w_trap_tval = '0;
                end
                SYSOP_EBREAK: begin
                    w_trap_cause[4:0] = 5'd3;
                    w_trap_tval = '0;
                end
                default: w_trap_cause[4:0] = r_cause;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid && (cause_in != 5'd0)) begin
                    case (cause_in)
                        SYSOP_CSRW, SYSOP_CSRS, SYSOP_CSRC: w_next = S_CSR_RD;
                        SYSOP_RET: w_next = S_RET;
                        default:   w_next = S_TRAP;
                    endcase
                end
            end
            S_CSR_RD: w_next = w_csr_illegal ? S_TRAP : S_CSR_WR;
            S_CSR_WR: w_next = S_IDLE;
            S_TRAP:   w_next = S_REDIR;
            S_RET:    w_next = (r_priv != 2'b11) ? S_TRAP : S_REDIR;
            S_REDIR:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cause        <= '0;
            r_rd           <= '0;
            r_tval         <= '0;
            r_pc           <= '0;
            r_wdata        <= '0;
            r_old          <= '0;
            r_illegal      <= 1'b0;
            r_priv         <= RESET_PRIV;
            r_mie          <= 1'b0;
            r_mpie         <= 1'b0;
            r_mpp          <= 2'b00;
            r_mtvec        <= '0;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
`ifdef SYSOP_MCYCLE_EN
            r_mcycle       <= '0;
`endif
            rd_we          <= 1'b0;
            rd_out         <= '0;
            rd_wdata       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            rd_we          <= 1'b0;
            redirect_valid <= 1'b0;
`ifdef SYSOP_MCYCLE_EN
            r_mcycle       <= r_mcycle + 1'b1;
`endif
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cause   <= cause_in;
                        r_tval    <= tval_in;
                        r_pc      <= pc_in;
                        r_wdata   <= wdata_in;
                        r_rd      <= rd_in;
                        r_illegal <= 1'b0;
                    end
                end
                S_CSR_RD: begin
                    r_old     <= w_csr_rdata;
                    r_illegal <= w_csr_illegal;
                end
                S_CSR_WR: begin
                    if (w_csr_wen) begin
                        case (w_addr)
                            12'h300: begin
                                r_mie  <= w_csr_new[3];
                                r_mpie <= w_csr_new[7];
                                r_mpp  <= w_csr_new[12:11];
                            end
                            12'h305: r_mtvec    <= {w_csr_new[XLEN-1:2], 2'b00};
                            12'h340: r_mscratch <= w_csr_new;
                            12'h341: r_mepc     <= {w_csr_new[XLEN-1:1], 1'b0};
                            12'h342: r_mcause   <= w_csr_new;
                            12'h343: r_mtval    <= w_csr_new;
`ifdef SYSOP_MCYCLE_EN
                            12'hB00: r_mcycle   <= w_csr_new;
`endif
                            default: ;
                        endcase
                    end
                    rd_we    <= 1'b1;
                    rd_out   <= r_rd;
                    rd_wdata <= r_old;
                end
                S_TRAP: begin
                    r_mepc      <= {r_pc[XLEN-1:1], 1'b0};
                    r_mcause    <= w_trap_cause;
                    r_mtval     <= w_trap_tval;
                    r_mpie      <= r_mie;
                    r_mie       <= 1'b0;
                    r_mpp       <= r_priv;
                    r_priv      <= 2'b11;
                    redirect_pc <= r_mtvec;
                end
                S_RET: begin
                    if (r_priv != 2'b11) begin
                        r_illegal <= 1'b1;
                    end else begin
                        r_priv      <= r_mpp;
                        r_mie       <= r_mpie;
                        r_mpie      <= 1'b1;
                        r_mpp       <= 2'b00;
                        redirect_pc <= r_mepc;
                    end
                end
                S_REDIR: redirect_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sysop_commit.sv
// Directed bench for sysop_commit: spec-level model predicts every pulse, checked each cycle.
module tb_sysop_commit;
    localparam logic [4:0] C_CSRW = 5'd16, C_CSRS = 5'd17, C_CSRC = 5'd18;
    localparam logic [4:0] C_RET = 5'd19, C_ECALL = 5'd20, C_EBREAK = 5'd21;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
    logic        in_ready, rd_we, redirect_valid;
    logic [4:0]  cause_in = '0, rd_in = '0, rd_out;
    logic [63:0] tval_in = '0, pc_in = '0, wdata_in = '0, rd_wdata, redirect_pc;
    logic [1:0]  priv;

    sysop_commit #(.XLEN(64), .RESET_PRIV(2'b11)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cause_in(cause_in), .tval_in(tval_in), .pc_in(pc_in), .wdata_in(wdata_in),
        .rd_in(rd_in), .priv(priv), .rd_we(rd_we), .rd_out(rd_out), .rd_wdata(rd_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // architectural model state
    logic [1:0]  m_priv;
    logic        m_mie, m_mpie;
    logic [1:0]  m_mpp;
    logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_cyc_base;
    int          m_cyc_edge;
    // expected output events (absolute cycle numbers)
    int          e_rd_cyc = -1, e_redir_cyc = -1, e_acc = 0, e_busy = 0;
    logic [4:0]  e_rd;
    logic [63:0] e_rd_data, e_redir_pc;
    bit          cmp_on = 1'b0;
    logic [63:0] last_rd_data = '0, last_redir_pc = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("rd_we", rd_we, cyc == e_rd_cyc);
            if (cyc == e_rd_cyc) begin
                chk("rd_out", rd_out, e_rd);
                chk("rd_wdata", rd_wdata, e_rd_data);
                last_rd_data = rd_wdata;
            end
            chk("redirect_valid", redirect_valid, cyc == e_redir_cyc);
            if (cyc == e_redir_cyc) begin
                chk("redirect_pc", redirect_pc, e_redir_pc);
                last_redir_pc = redirect_pc;
            end
            chk("in_ready", in_ready, !(cyc >= e_acc && cyc < e_busy));
            if (cyc >= e_busy) chk("priv", priv, m_priv);
        end
    end

    task automatic model_reset(input int edge_no);
        m_priv = 2'b11; m_mie = 0; m_mpie = 0; m_mpp = 0;
        m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc_base = 0; m_cyc_edge = edge_no;
        e_rd_cyc = -1; e_redir_cyc = -1; e_acc = edge_no; e_busy = edge_no;
    endtask

    task automatic model_read(input logic [11:0] a, input int k, output bit hit, output logic [63:0] v);
        hit = 1'b1;
        v = 0;
        case (a)
            12'h300: v = (64'(m_mpp) << 11) | (64'(m_mpie) << 7) | (64'(m_mie) << 3);
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'hF14: v = 0;
`ifdef SYSOP_MCYCLE_EN
            12'hB00: v = m_cyc_base + 64'(k - m_cyc_edge);
`endif
            default: hit = 1'b0;
        endcase
    endtask

    task automatic model_write(input logic [11:0] a, input logic [63:0] v, input int edge_no);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; m_mpp = v[12:11]; end
            12'h305: m_mtvec = v & ~64'd3;
            12'h340: m_mscratch = v;
            12'h341: m_mepc = v & ~64'd1;
            12'h342: m_mcause = v;
            12'h343: m_mtval = v;
            12'hB00: begin m_cyc_base = v; m_cyc_edge = edge_no; end
            default: ;
        endcase
    endtask

    task automatic model_trap(input logic [63:0] c, input logic [63:0] tv, input logic [63:0] pc);
        m_mepc = pc & ~64'd1; m_mcause = c; m_mtval = tv;
        m_mpie = m_mie; m_mie = 0; m_mpp = m_priv; m_priv = 2'b11;
        e_redir_pc = m_mtvec;
    endtask

    // Presents one op for a single cycle, predicting its effects from the architectural rules.
    task automatic issue(input logic [4:0] c, input logic [63:0] tv, input logic [63:0] pc,
                         input logic [63:0] wd, input logic [4:0] rd);
        int k;
        bit hit, ill;
        logic [63:0] old, nv;
        logic [11:0] a;
        k = cyc + 1;
        cause_in = c; tval_in = tv; pc_in = pc; wdata_in = wd; rd_in = rd; in_valid = 1'b1;
        e_acc = k; e_busy = k;
        if (c inside {C_CSRW, C_CSRS, C_CSRC}) begin
            a = tv[11:0];
            model_read(a, k, hit, old);
            ill = !hit || (a[9:8] > m_priv) || (a[11:10] == 2'b11 && (c == C_CSRW || wd != 0));
            if (ill) begin
                model_trap(64'd2, {52'd0, a}, pc);
                e_redir_cyc = k + 3; e_busy = k + 3;
            end else begin
                case (c)
                    C_CSRW:  nv = wd;
                    C_CSRS:  nv = old | wd;
                    default: nv = old & ~wd;
                endcase
                if (c == C_CSRW || wd != 0) model_write(a, nv, k + 2);
                e_rd_cyc = k + 2; e_rd = rd; e_rd_data = old; e_busy = k + 2;
            end
        end else if (c == C_RET) begin
            if (m_priv != 2'b11) begin
                model_trap(64'd2, 64'd0, pc);
                e_redir_cyc = k + 3; e_busy = k + 3;
            end else begin
                m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1; m_mpp = 0;
                e_redir_pc = m_mepc; e_redir_cyc = k + 2; e_busy = k + 2;
            end
        end else if (c != 0) begin
            if (c == C_ECALL)
                model_trap(m_priv == 2'b00 ? 64'd8 : m_priv == 2'b01 ? 64'd9 : 64'd11, 64'd0, pc);
            else if (c == C_EBREAK)
                model_trap(64'd3, 64'd0, pc);
            else
                model_trap({59'd0, c}, tv, pc);
            e_redir_cyc = k + 2; e_busy = k + 2;
        end
        @(posedge clk); #1;
        // scramble inputs after acceptance: the DUT must work from its latched copy
        in_valid = 1'b0; cause_in = '0; tval_in = '1; pc_in = '1; wdata_in = '1; rd_in = '1;
    endtask

    task automatic settle();
        while (cyc < e_busy) begin @(posedge clk); #1; end
        @(negedge clk); #1;
    endtask

    task automatic op(input logic [4:0] c, input logic [63:0] tv, input logic [63:0] pc,
                      input logic [63:0] wd, input logic [4:0] rd);
        issue(c, tv, pc, wd, rd);
        settle();
    endtask

    task automatic rd_csr(input logic [11:0] a);
        op(C_CSRS, {52'd0, a}, 64'h0, 64'h0, 5'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        model_reset(cyc);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset_rd_we", rd_we, 1'b0);
        chk("reset_redirect_valid", redirect_valid, 1'b0);
        chk("reset_rd_wdata", rd_wdata, 64'h0);
        chk("reset_redirect_pc", redirect_pc, 64'h0);
        chk("reset_priv", priv, 2'b11);
        chk("reset_in_ready", in_ready, 1'b1);
        cmp_on = 1'b1;

        op(C_CSRW, 64'h305, 64'h0, 64'h8000_0003, 5'd5);
        chk("mtvec_old", last_rd_data, 64'h0);
        rd_csr(12'h305);
        chk("mtvec_masked", last_rd_data, 64'h8000_0000);

        op(C_ECALL, 64'h55, 64'h1000, 64'h0, 5'd0);
        chk("ecall_redirect", last_redir_pc, 64'h8000_0000);
        rd_csr(12'h342); chk("ecall_m_mcause", last_rd_data, 64'd11);
        rd_csr(12'h341); chk("ecall_mepc", last_rd_data, 64'h1000);
        rd_csr(12'h300); chk("ecall_mstatus", last_rd_data, 64'h1800);
        rd_csr(12'h343); chk("ecall_mtval", last_rd_data, 64'h0);

        op(C_CSRC, 64'h300, 64'h0, 64'h1800, 5'd2);
        op(C_RET, 64'h0, 64'h8000_0000, 64'h0, 5'd0);
        chk("mret_redirect", last_redir_pc, 64'h1000);
        chk("mret_priv_u", priv, 2'b00);
        op(C_CSRS, 64'h300, 64'h1004, 64'h0, 5'd3);
        rd_csr(12'h342); chk("u_csr_mcause", last_rd_data, 64'd2);
        rd_csr(12'h343); chk("u_csr_mtval", last_rd_data, 64'h300);

        rd_csr(12'hF14); chk("mhartid", last_rd_data, 64'h0);
        op(C_CSRW, 64'hF14, 64'h1100, 64'h1, 5'd4);
        rd_csr(12'h342); chk("ro_write_mcause", last_rd_data, 64'd2);
        rd_csr(12'h343); chk("ro_write_mtval", last_rd_data, 64'hF14);

        op(C_CSRW, 64'h340, 64'h0, 64'h0123_4567_89AB_CDEF, 5'd7);
        op(C_CSRS, 64'h340, 64'h0, 64'hF0, 5'd7);
        op(C_CSRC, 64'h340, 64'h0, 64'h0F, 5'd0);
        chk("mscratch_set", last_rd_data, 64'h0123_4567_89AB_CDFF);
        rd_csr(12'h340); chk("mscratch_clr", last_rd_data, 64'h0123_4567_89AB_CDF0);

        op(C_CSRW, 64'h300, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8);
        rd_csr(12'h300); chk("mstatus_mask", last_rd_data, 64'h1888);
        op(C_CSRC, 64'h300, 64'h0, 64'h1888, 5'd8);
        op(C_CSRS, 64'h300, 64'h0, 64'h0800, 5'd8);
        op(C_CSRW, 64'h341, 64'h0, 64'h2001, 5'd8);
        op(C_RET, 64'h0, 64'h0, 64'h0, 5'd0);
        chk("mret_to_s_redirect", last_redir_pc, 64'h2000);
        chk("mret_priv_s", priv, 2'b01);
        op(C_ECALL, 64'h0, 64'h2000, 64'h0, 5'd0);
        rd_csr(12'h342); chk("ecall_s_mcause", last_rd_data, 64'd9);

        op(C_CSRW, 64'h305, 64'h0, 64'h4000, 5'd9);
        op(C_EBREAK, 64'h77, 64'h2222, 64'h0, 5'd0);
        chk("new_mtvec_redirect", last_redir_pc, 64'h4000);
        rd_csr(12'h343); chk("ebreak_mtval", last_rd_data, 64'h0);
        rd_csr(12'h342); chk("ebreak_mcause", last_rd_data, 64'd3);

        op(5'd5, 64'h1234, 64'h3001, 64'h0, 5'd0);
        rd_csr(12'h342); chk("prop_mcause", last_rd_data, 64'd5);
        rd_csr(12'h343); chk("prop_mtval", last_rd_data, 64'h1234);
        rd_csr(12'h341); chk("prop_mepc", last_rd_data, 64'h3000);

        op(5'd0, 64'hFFF, 64'h9999, 64'h1, 5'd1);
        rd_csr(12'h342); chk("noop_mcause", last_rd_data, 64'd5);

        op(C_CSRC, 64'h300, 64'h0, 64'h1800, 5'd0);
        op(C_RET, 64'h0, 64'h0, 64'h0, 5'd0);
        chk("mret_u_redirect", last_redir_pc, 64'h3000);
        op(C_RET, 64'h0, 64'h3000, 64'h0, 5'd0);
        rd_csr(12'h342); chk("u_mret_mcause", last_rd_data, 64'd2);
        rd_csr(12'h343); chk("u_mret_mtval", last_rd_data, 64'h0);

`ifdef SYSOP_MCYCLE_EN
        op(C_CSRW, 64'hB00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'd10);
        @(posedge clk); #1;
        rd_csr(12'hB00); chk("mcycle_wrap", last_rd_data, 64'd1);
`else
        op(C_CSRW, 64'hB00, 64'h0, 64'h5, 5'd10);
        rd_csr(12'h342); chk("mcycle_absent_mcause", last_rd_data, 64'd2);
        rd_csr(12'h343); chk("mcycle_absent_mtval", last_rd_data, 64'hB00);
`endif

        issue(C_ECALL, 64'h0, 64'h5000, 64'h0, 5'd0);
        do_reset();
        @(negedge clk); #1;
        chk("rst_trap_in_ready", in_ready, 1'b1);
        chk("rst_trap_no_redirect", redirect_valid, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        rd_csr(12'h341); chk("rst_trap_mepc", last_rd_data, 64'h0);
        rd_csr(12'h305); chk("rst_trap_mtvec", last_rd_data, 64'h0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: test did not finish by time %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
